// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Parametrised UART transmitter with valid/ready FIFO front end,
//               clock-enable baud divider and back-to-back frame output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int c_div   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int c_cnt_w = $clog2(c_div);
  localparam int c_aw    = $clog2(FIFO_DEPTH);
  localparam int c_bc_w  = $clog2(DATA_BITS);

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(c_div - 1);
  localparam logic [c_bc_w-1:0]  c_data_last = c_bc_w'(DATA_BITS - 1);
  localparam logic [c_bc_w-1:0]  c_stop_last = c_bc_w'(STOP_BITS - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  generate
    if (c_div < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_tx_fifo: illegal parameter set");
    end
  endgenerate

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw:0]        r_wr_ptr;
  logic [c_aw:0]        r_rd_ptr;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic [DATA_BITS-1:0] w_head;

  logic [2:0]           r_state;
  logic [c_cnt_w-1:0]   r_baud_cnt;
  logic [c_bc_w-1:0]    r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;
  logic                 w_tick;
  logic                 w_last_stop;
  logic                 w_load;

  // Extra pointer bit distinguishes full from empty so every entry is usable.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                      (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign fifo_level = r_wr_ptr - r_rd_ptr;
  assign s_ready    = !w_full;
  assign w_push     = s_valid && s_ready;
  assign w_head     = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign w_tick      = (r_baud_cnt == c_cnt_last);
  assign w_last_stop = (r_state == c_st_stop) && w_tick && (r_bit_cnt == c_stop_last);
  // Loading at the final stop boundary chains frames with no idle gap.
  assign w_load      = !w_empty && ((r_state == c_st_idle) || w_last_stop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_st_idle;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last_stop;
      if (w_load || w_tick || r_state == c_st_idle) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end

      if (w_load) begin
        r_shift   <= w_head;
        r_par     <= (PARITY == 1) ? ~^w_head : ^w_head;
        r_tx      <= 1'b0;
        r_bit_cnt <= '0;
        r_state   <= c_st_start;
      end else if (w_tick) begin
        case (r_state)
          c_st_start: begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= c_st_data;
          end
          c_st_data: begin
            if (r_bit_cnt == c_data_last) begin
              r_bit_cnt <= '0;
              if (PARITY != 0) begin
                r_tx    <= r_par;
                r_state <= c_st_parity;
              end else begin
                r_tx    <= 1'b1;
                r_state <= c_st_stop;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          c_st_parity: begin
            r_tx    <= 1'b1;
            r_state <= c_st_stop;
          end
          c_st_stop: begin
            if (r_bit_cnt == c_stop_last) begin
              r_tx    <= 1'b1;
              r_state <= c_st_idle;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: begin
            r_tx    <= 1'b1;
            r_state <= c_st_idle;
          end
        endcase
      end
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != c_st_idle);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo across 8N1, 8E2, 8O2, 7N1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DIV = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       par;
  } frame_t;

  logic       clk = 1'b0;
  logic [3:0] rst_v  = 4'b0000;
  logic [3:0] sval_v = 4'b0000;
  logic [3:0] srdy_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [7:0] sd0 = '0;
  logic [7:0] sd1 = '0;
  logic [7:0] sd2 = '0;
  logic [6:0] sd3 = '0;
  logic [2:0] lvl0, lvl1, lvl2, lvl3;

  frame_t exp_q[4][$];
  int     done_cnt[4];
  int     b2b_cnt[4];
  bit     in_frame[4];
  int     cyc   = 0;
  int     n_chk = 0;
  int     n_err = 0;

  logic [7:0] words[6] = '{8'h01, 8'h80, 8'hA5, 8'h3C, 8'hFF, 8'h5A};

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst_v[0]), .s_data(sd0), .s_valid(sval_v[0]), .s_ready(srdy_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .fifo_level(lvl0));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8e2 (
    .clk(clk), .rst(rst_v[1]), .s_data(sd1), .s_valid(sval_v[1]), .s_ready(srdy_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .fifo_level(lvl1));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8o2 (
    .clk(clk), .rst(rst_v[2]), .s_data(sd2), .s_valid(sval_v[2]), .s_ready(srdy_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .fifo_level(lvl2));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7n1 (
    .clk(clk), .rst(rst_v[3]), .s_data(sd3), .s_valid(sval_v[3]), .s_ready(srdy_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]), .fifo_level(lvl3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  task automatic chk(input bit ok, input string nm, input int act, input int expv);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic set_data(input int idx, input logic [8:0] d);
    case (idx)
      0:       sd0 = d[7:0];
      1:       sd1 = d[7:0];
      2:       sd2 = d[7:0];
      default: sd3 = d[6:0];
    endcase
  endtask

  task automatic expect_frame(input int idx, input logic [8:0] d, input logic p);
    frame_t f;
    f.data = d;
    f.par  = p;
    exp_q[idx].push_back(f);
  endtask

  // Drives one word; p is the hand-computed parity bit the line must carry.
  task automatic push(input int idx, input logic [8:0] d, input logic p);
    int t = 0;
    @(negedge clk);
    set_data(idx, d);
    sval_v[idx] = 1'b1;
    while (!srdy_v[idx] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(srdy_v[idx] === 1'b1, "push_ready", srdy_v[idx], 1);
    @(posedge clk);
    expect_frame(idx, d, p);
    #1 sval_v[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx, input int budget);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((in_frame[idx] || busy_v[idx] || exp_q[idx].size() != 0) && t < budget);
    chk(t < budget, "drain_timeout", t, budget);
    repeat (2) @(negedge clk);
  endtask

  // Serial-line receiver: checks every cycle of every bit, busy, and done timing.
  task automatic monitor(input int idx, input int db, input int hp, input int sb);
    frame_t      e;
    logic [15:0] bits;
    int          nb;
    bit          bad, aborted, b2b;
    int          got;
    nb  = 1 + db + hp + sb;
    b2b = 0;
    @(negedge clk);
    forever begin
      while (!(rst_v[idx] === 1'b1 && tx_v[idx] === 1'b0)) begin
        @(negedge clk);
        b2b = 0;
      end
      in_frame[idx] = 1'b1;
      if (b2b) b2b_cnt[idx]++;
      if (exp_q[idx].size() == 0) begin
        chk(1'b0, "spurious_frame", idx, -1);
        e = '0;
      end else begin
        e = exp_q[idx].pop_front();
      end
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < db; i++) bits[1 + i] = e.data[i];
      if (hp != 0) bits[1 + db] = e.par;
      aborted = 0;
      for (int b = 0; b < nb && !aborted; b++) begin
        bad = 0;
        got = 0;
        for (int j = 0; j < DIV; j++) begin
          if (b != 0 || j != 0) @(negedge clk);
          if (rst_v[idx] !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (!bad && (tx_v[idx] !== bits[b] || busy_v[idx] !== 1'b1 ||
                       (done_v[idx] !== 1'b0 && (b != 0 || j != 0)))) begin
            bad = 1;
            got = {busy_v[idx], done_v[idx], tx_v[idx]};
          end
        end
        if (!aborted)
          chk(!bad, $sformatf("frame_bit inst%0d data 0x%0h bit%0d {busy,done,tx}", idx, e.data, b),
              got, {1'b1, 1'b0, bits[b]});
      end
      if (!aborted) begin
        @(negedge clk);
        if (rst_v[idx] === 1'b1) begin
          chk(done_v[idx] === 1'b1, "done_at_frame_end", done_v[idx], 1);
          chk(busy_v[idx] === ~tx_v[idx], "busy_after_frame", busy_v[idx], ~tx_v[idx]);
          b2b = 1;
        end
      end else begin
        b2b = 0;
      end
      in_frame[idx] = 1'b0;
    end
  endtask

  initial monitor(0, 8, 0, 1);
  initial monitor(1, 8, 1, 2);
  initial monitor(2, 8, 1, 2);
  initial monitor(3, 7, 0, 1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0, bb0, k, t;
    int  acc[6];
    bit  rdy, low;

    repeat (3) @(negedge clk);
    chk(tx_v[0] === 1'b1, "reset_tx", tx_v[0], 1);
    chk(busy_v[0] === 1'b0, "reset_busy", busy_v[0], 0);
    chk(done_v[0] === 1'b0, "reset_done", done_v[0], 0);
    chk(srdy_v[0] === 1'b1, "reset_s_ready", srdy_v[0], 1);
    chk(lvl0 === 3'd0, "reset_level", lvl0, 0);
    rst_v = 4'hF;
    repeat (2) @(negedge clk);

    // 8N1 0x55: acceptance latency, then full frame via the monitor
    push(0, 9'h055, 1'b0);
    @(negedge clk);
    chk(lvl0 === 3'd1, "level_after_push", lvl0, 1);
    chk(busy_v[0] === 1'b0 && tx_v[0] === 1'b1, "idle_at_push_edge", {busy_v[0], tx_v[0]}, 1);
    @(negedge clk);
    chk(busy_v[0] === 1'b1 && tx_v[0] === 1'b0, "start_after_pop", {busy_v[0], tx_v[0]}, 2);
    chk(lvl0 === 3'd0, "level_after_pop", lvl0, 0);
    wait_idle(0, 400);
    chk(done_cnt[0] == 1, "single_done_8n1", done_cnt[0], 1);

    // Parity and frame-length configurations: 0x07 even -> 1, odd -> 0
    push(1, 9'h007, 1'b1);
    push(2, 9'h007, 1'b0);
    push(3, 9'h02A, 1'b0);
    push(3, 9'h07F, 1'b0);
    wait_idle(1, 600);
    wait_idle(2, 600);
    wait_idle(3, 800);
    chk(done_cnt[1] == 1, "done_8e2", done_cnt[1], 1);
    chk(done_cnt[2] == 1, "done_8o2", done_cnt[2], 1);
    chk(done_cnt[3] == 2, "done_7n1", done_cnt[3], 2);

    // FIFO fill with s_valid held high across six words
    d0  = done_cnt[0];
    bb0 = b2b_cnt[0];
    k   = 0;
    t   = 0;
    @(negedge clk);
    sval_v[0] = 1'b1;
    while (k < 6 && t < 2000) begin
      sd0 = words[k];
      rdy = srdy_v[0];
      @(posedge clk);
      if (rdy) begin
        expect_frame(0, {1'b0, words[k]}, 1'b0);
        k++;
      end
      @(negedge clk);
      if (rdy) acc[k-1] = cyc;
      if (rdy && k == 5) begin
        chk(lvl0 === 3'd4, "level_full", lvl0, 4);
        chk(srdy_v[0] === 1'b0, "s_ready_full", srdy_v[0], 0);
      end
      t++;
    end
    sval_v[0] = 1'b0;
    chk(k == 6, "fifo_all_accepted", k, 6);
    for (int i = 1; i < 5; i++)
      chk(acc[i] == acc[0] + i, "fifo_consecutive_accept", acc[i] - acc[0], i);
    chk(acc[5] == acc[0] + 162, "word6_accept_edge", acc[5] - acc[0], 162);
    wait_idle(0, 6 * 160 + 400);
    chk(done_cnt[0] - d0 == 6, "six_done_pulses", done_cnt[0] - d0, 6);
    chk(b2b_cnt[0] - bb0 == 5, "back_to_back_frames", b2b_cnt[0] - bb0, 5);

    // Asynchronous reset mid-DATA with two words queued
    push(0, 9'h011, 1'b0);
    push(0, 9'h022, 1'b0);
    push(0, 9'h033, 1'b0);
    repeat (4 * DIV) @(negedge clk);
    chk(lvl0 === 3'd2, "queued_before_reset", lvl0, 2);
    chk(busy_v[0] === 1'b1, "busy_before_reset", busy_v[0], 1);
    d0 = done_cnt[0];
    @(posedge clk);
    #2 rst_v[0] = 1'b0;
    #1;
    chk(tx_v[0] === 1'b1, "async_reset_tx", tx_v[0], 1);
    chk(busy_v[0] === 1'b0, "async_reset_busy", busy_v[0], 0);
    chk(lvl0 === 3'd0, "async_reset_level", lvl0, 0);
    chk(done_v[0] === 1'b0, "async_reset_done", done_v[0], 0);
    chk(srdy_v[0] === 1'b1, "async_reset_s_ready", srdy_v[0], 1);
    exp_q[0].delete();
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    low = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) low = 1;
    end
    chk(!low, "idle_after_reset", low, 0);
    chk(done_cnt[0] == d0, "no_done_on_reset", done_cnt[0] - d0, 0);
    push(0, 9'h0C3, 1'b0);
    wait_idle(0, 400);
    chk(done_cnt[0] == d0 + 1, "frame_after_reset", done_cnt[0] - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
